// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through fetch, decode, execute, memory and write-back states
// and drives Moore-decoded datapath strobes for the current state. pc_write is qualified by
// mem_ready in FETCH and by the ALU zero flag in BRANCH. Illegal opcodes park the unit in
// TRAP with a sticky flag until reset. Retired instructions are counted modulo 2^CNT_W.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   op, funct, zero       instruction fields and ALU zero flag
//   mem_ready             memory access completes this cycle
//   pc_write .. pc_source datapath strobes and mux selects
//   state                 current state (debug)
//   illegal_op            sticky illegal-opcode trap flag
//   retire_count          retired instruction counter
module multicycle_control #(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned CNT_W      = 32,
  parameter bit          ENABLE_JAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retire_count
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr, StRExec, StRWb,
    StIExec, StIWb, StBranch, StJump, StJr, StJal, StTrap
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [2:0] AluRType = 3'b111;
  localparam logic [2:0] AluAdd   = 3'b100;
  localparam logic [2:0] AluOr    = 3'b101;
  localparam logic [2:0] AluAnd   = 3'b110;
  localparam logic [2:0] AluLui   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b011;

  state_e           state_q, state_d;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic [2:0]       alu_op3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      // Later states need the opcode but it is only sampled here.
      if (state_q == StDecode) op_q <= op;
      if (state_q == StDecode && state_d == StTrap) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpRType:                     state_d = (funct == FnJr) ? StJr : StRExec;
          OpAddi, OpOri, OpAndi, OpLui: state_d = StIExec;
          OpLw, OpSw:                  state_d = StMemAddr;
          OpBeq, OpBne:                state_d = StBranch;
          OpJ:                         state_d = StJump;
          OpJal:                       state_d = ENABLE_JAL ? StJal : StTrap;
          default:                     state_d = StTrap;
        endcase
      end
      StMemAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRExec: state_d = StRWb;
      StIExec: state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump, StJr, StJal: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op3    = AluLui;
    pc_source  = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op3   = AluAdd;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        alu_op3   = AluAdd;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op3   = AluAdd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op3   = AluRType;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OpOri:   alu_op3 = AluOr;
          OpAndi:  alu_op3 = AluAnd;
          OpLui:   alu_op3 = AluLui;
          default: alu_op3 = AluAdd;
        endcase
      end
      StIWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op3   = AluSub;
        pc_source = 2'b01;
        pc_write  = (op_q == OpBeq) ? zero : !zero;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StJr: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      StJal: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      default: ;
    endcase
    // Side-effecting strobes are suppressed while reset is held.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign alu_op       = ALUOP_W'(alu_op3);
  assign state        = state_q;
  assign illegal_op   = illegal_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .CNT_W(32), .ENABLE_JAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op), .retire_count(retire_count)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, iord, mrd, mwr, irw;
    logic [1:0]  rdst, m2r;
    logic        rw, asa;
    logic [1:0]  asb;
    logic [2:0]  aop;
    logic [1:0]  psrc;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   br_pcw[$];
  int   m_ret;
  bit   m_ill;
  logic [5:0] m_op;
  bit   m_zero;

  // Expected outputs for one cycle, written from the per-state strobe table.
  function automatic exp_t model(int st, bit rdy);
    exp_t e = '0;
    e.st  = 4'(st);
    e.ill = m_ill;
    e.cnt = m_ret;
    case (st)
      0:  begin e.mrd = 1; e.asb = 2'b01; e.aop = 3'b100; e.irw = rdy; e.pcw = rdy; end
      1:  begin e.asb = 2'b11; e.aop = 3'b100; end
      2:  begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b100; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 2'b01; end
      5:  begin e.mwr = 1; e.iord = 1; end
      6:  begin e.asa = 1; e.aop = 3'b111; end
      7:  begin e.rw = 1; e.rdst = 2'b01; end
      8:  begin
        e.asa = 1; e.asb = 2'b10;
        e.aop = (m_op == 6'h0d) ? 3'b101 : (m_op == 6'h0c) ? 3'b110 :
                (m_op == 6'h0f) ? 3'b000 : 3'b100;
      end
      9:  e.rw = 1;
      10: begin
        e.asa = 1; e.aop = 3'b011; e.psrc = 2'b01;
        e.pcw = (m_op == 6'h04) ? m_zero : !m_zero;
      end
      11: begin e.pcw = 1; e.psrc = 2'b10; end
      12: begin e.pcw = 1; e.psrc = 2'b11; end
      13: begin e.pcw = 1; e.psrc = 2'b10; e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit rnd();
    return ($urandom & 1) == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock cycle: drive mem_ready, queue the expected outputs, advance past the edge.
  task automatic cyc(input int st, input bit rdy, input bit retires);
    mem_ready = rdy;
    exp_q.push_back(model(st, rdy));
    @(posedge clk);
    #1;
    if (retires) m_ret++;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                           input int fw, input int mw);
    m_op = o; m_zero = z;
    op = o; funct = f; zero = z;
    repeat (fw) cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(1, rnd(), 1'b0);
    // The opcode fields are only meaningful in DECODE; scramble them afterwards.
    op = 6'($urandom); funct = 6'($urandom);
    if (o == 6'h00 && f == 6'h08) cyc(12, rnd(), 1'b1);
    else if (o == 6'h00) begin cyc(6, rnd(), 1'b0); cyc(7, rnd(), 1'b1); end
    else if (o == 6'h08 || o == 6'h0d || o == 6'h0c || o == 6'h0f) begin
      cyc(8, rnd(), 1'b0); cyc(9, rnd(), 1'b1);
    end else if (o == 6'h23) begin
      cyc(2, rnd(), 1'b0);
      repeat (mw) cyc(3, 1'b0, 1'b0);
      cyc(3, 1'b1, 1'b0);
      cyc(4, rnd(), 1'b1);
    end else if (o == 6'h2b) begin
      cyc(2, rnd(), 1'b0);
      repeat (mw) cyc(5, 1'b0, 1'b0);
      cyc(5, 1'b1, 1'b1);
    end else if (o == 6'h04 || o == 6'h05) cyc(10, rnd(), 1'b1);
    else if (o == 6'h02) cyc(11, rnd(), 1'b1);
    else if (o == 6'h03) cyc(13, rnd(), 1'b1);
    else begin
      m_ill = 1'b1;
      cyc(14, rnd(), 1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, retire_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_state%0d: got %h expected %h", e.st, a, e);
      end
      if (state == 4'd10) br_pcw.push_back(pc_write);
    end
  end

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    m_ret = 0; m_ill = 1'b0; m_op = '0; m_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_count", retire_count, 0);
    chk("rst_mem_read_forced", 32'(mem_read), 0);
    reset = 1'b0;

    run_instr(6'h08, 6'h00, 1'b0, 0, 0);
    chk("addi_count", retire_count, 1);
    chk("addi_back_to_fetch", 32'(state), 0);
    run_instr(6'h0d, 6'h00, 1'b0, 1, 0);
    run_instr(6'h0c, 6'h00, 1'b1, 0, 0);
    run_instr(6'h0f, 6'h00, 1'b0, 2, 0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 2);
    chk("lw_7cyc_fetch", 32'(state), 0);
    chk("lw_count", retire_count, 6);
    run_instr(6'h2b, 6'h00, 1'b0, 1, 1);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);
    chk("branch_count", 32'(br_pcw.size()), 4);
    if (br_pcw.size() == 4) begin
      chk("beq_z1_pcw", 32'(br_pcw[0]), 1);
      chk("beq_z0_pcw", 32'(br_pcw[1]), 0);
      chk("bne_z0_pcw", 32'(br_pcw[2]), 1);
      chk("bne_z1_pcw", 32'(br_pcw[3]), 0);
    end
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
    chk("retired_14", retire_count, 14);

    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    repeat (10) cyc(14, rnd(), 1'b0);
    chk("trap_state", 32'(state), 14);
    chk("trap_sticky", 32'(illegal_op), 1);
    chk("trap_no_retire", retire_count, 14);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ret = 0; m_ill = 1'b0;
    chk("trap_rst_state", 32'(state), 0);
    chk("trap_rst_illegal", 32'(illegal_op), 0);
    chk("trap_rst_count", retire_count, 0);

    // Abort a store while MEM_WR is waiting on memory.
    m_op = 6'h2b; op = 6'h2b; funct = '0;
    cyc(0, 1'b1, 1'b0);
    cyc(1, rnd(), 1'b0);
    cyc(2, rnd(), 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("memwr_before_rst", 32'(mem_write), 1);
    reset = 1'b1;
    #1;
    chk("memwr_rst_same_cycle", 32'(mem_write), 0);
    chk("memwr_rst_state", 32'(state), 5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("memwr_abort_fetch", 32'(state), 0);
    chk("memwr_abort_count", retire_count, 0);
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);
    chk("post_abort_count", retire_count, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the MIPS datapath, next generation of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives per-state datapath strobes. It honours a memory ready handshake and resolves branches from the ALU zero flag. It adds BEQ/BNE, J, JAL and JR (R-type funct 0x08), traps illegal opcodes, and counts retired instructions.

## Interface
- ALUOP_W, 3, width of alu_op. Encodings: 111 R-type (ALU decodes funct), 100 ADD, 101 OR, 110 AND, 000 LUI, 011 SUB; upper bits are zero when ALUOP_W > 3.
- CNT_W, 32, width of retire_count.
- ENABLE_JAL, 1, when 0 the JAL opcode is treated as illegal.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from the instruction register.
- funct  in  6  funct field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  PC load enable, with the branch condition already resolved.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  2  destination register: 00 rt, 01 rd, 10 $ra (31).
- mem_to_reg  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU operand B: 00 rt, 01 constant 4, 10 sign/zero-extended immediate, 11 immediate shifted left by 2.
- alu_op  out  ALUOP_W  ALU operation select.
- pc_source  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- state  out  4  current state, for debug.
- illegal_op  out  1  sticky trap flag.
- retire_count  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W.

## Operation
- All outputs are Moore-decoded from state; only pc_write (FETCH, BRANCH) and the memory-state exits are qualified by mem_ready or zero. Outputs not listed for a state are 0.
- FETCH (0): mem_read=1, iord=0.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; go to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=ADD, which precomputes the branch target into ALUOut. Dispatch on op:
  - 0x00 with funct 0x08 goes to JR; any other funct goes to R_EXEC.
  - 0x08, 0x0d, 0x0c, 0x0f go to I_EXEC.
  - 0x23, 0x2b go to MEM_ADDR.
  - 0x04, 0x05 go to BRANCH.
  - 0x02 goes to JUMP.
  - 0x03 goes to JAL.
  - Anything else goes to TRAP.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD (3): mem_read=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB (4): reg_write=1, reg_dst=00, mem_to_reg=01; retire; go to FETCH.
- MEM_WR (5): mem_write=1, iord=1. Hold until mem_ready, then retire and go to FETCH.
- R_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=111.
- R_WB (7): reg_write=1, reg_dst=01, mem_to_reg=00; retire.
- I_EXEC (8): alu_src_a=1, alu_src_b=10. alu_op is ADD, OR, AND or LUI for ADDI, ORI, ANDI or LUI respectively.
- I_WB (9): reg_write=1, reg_dst=00, mem_to_reg=00; retire.
- BRANCH (10): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write = zero for BEQ, !zero for BNE. Retire.
- JUMP (11): pc_write=1, pc_source=10; retire.
- JR (12): pc_write=1, pc_source=11; retire.
- JAL (13): pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; retire. Register write and PC update happen on the same edge, so the register file sees the already-incremented PC.
- TRAP (14): set illegal_op. All strobes stay 0 and the unit stays in TRAP until reset.
- Every retire returns to FETCH and adds 1 to retire_count. TRAP never retires.
- State 15 is unreachable; if entered, go to FETCH.

## Timing
- Reset (synchronous, high) on a clock edge sets:
  - state=FETCH, illegal_op=0, retire_count=0;
  - all outputs that are not Moore-decoded from state to 0.
- While reset is high, pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0.
- Reset asserted mid-instruction aborts the instruction with no retire; the unit is in FETCH on the cycle after reset deasserts.
- Cycle counts per instruction, with zero memory wait (mem_ready=1 on first request):

  | Instruction | Cycles |
  |---|---|
  | LW | 5 |
  | SW, R-type, I-type | 4 |
  | BEQ/BNE, J, JR, JAL | 3 |

- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- op and funct are sampled in DECODE only. IR changes only on an ir_write edge.
- mem_ready seen outside FETCH, MEM_RD or MEM_WR is ignored.

## Test plan
- Reset, then ADDI (op 0x08) with mem_ready held 1:
  - state sequence is 0,1,8,9,0;
  - reg_write=1 only in state 9;
  - retire_count goes 0→1.
- LW with mem_ready=0 for 2 cycles in MEM_RD:
  - takes 7 cycles total;
  - mem_read and iord stay 1 across the wait;
  - reg_write pulses once, with mem_to_reg=01.
- BEQ with zero=1, then BEQ with zero=0, then BNE with zero=0:
  - pc_write in BRANCH is 1, 0, 1 respectively;
  - pc_source=01 each time.
- JR (op 0, funct 0x08): pc_source=11, reg_write=0 throughout. JAL: reg_dst=10, mem_to_reg=10, reg_write=1.
- Illegal opcode 0x3f: state goes to 14 and illegal_op=1. illegal_op stays 1 for 10 further cycles with all strobes 0; reset clears it.
- Reset asserted in MEM_WR:
  - mem_write drops to 0 in the same cycle;
  - the unit is in FETCH the cycle after reset deasserts;
  - retire_count is 0.
